// File: rtl/chf_pll_pkg.sv
// chf_pll_pkg
// Shared definitions for the PLL reconfiguration sequencer:
//   - state_t : sequencer states (LOCKWAIT exists only when
//               CHF_PLL_LOCK_WAIT_EN is defined)
//   - ADDR_*  : register addresses of the PLL reconfiguration port
//   - is_write_state() : true for states that drive a write on the port
package chf_pll_pkg;

`ifdef CHF_PLL_LOCK_WAIT_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MODE,
    ST_NCNT,
    ST_MCNT,
    ST_C0,
    ST_MFRAC,
    ST_START,
    ST_LOCKWAIT
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MODE,
    ST_NCNT,
    ST_MCNT,
    ST_C0,
    ST_MFRAC,
    ST_START
  } state_t;
`endif

  localparam logic [5:0] ADDR_MODE  = 6'd0;
  localparam logic [5:0] ADDR_START = 6'd2;
  localparam logic [5:0] ADDR_N     = 6'd3;
  localparam logic [5:0] ADDR_M     = 6'd4;
  localparam logic [5:0] ADDR_C0    = 6'd5;
  localparam logic [5:0] ADDR_MFRAC = 6'd7;

  function automatic logic is_write_state(state_t s);
    logic w;
    w = 1'b0;
    case (s)
      ST_MODE, ST_NCNT, ST_MCNT, ST_C0, ST_MFRAC, ST_START: w = 1'b1;
      default: w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/chf_pll_reconfig_sync2.sv
// chf_sync2
// Two-flop synchronizer for a single asynchronous level signal.
// Ports:
//   clk     in  : destination clock
//   reset_n in  : asynchronous active-low reset (output resets to 0)
//   d       in  : asynchronous input
//   q       out : synchronized output
module chf_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/chf_pll_reconfig.sv
// chf_pll_reconfig
// Reprograms the system PLL through its Avalon-MM reconfiguration port
// whenever the NTSC/PAL standard changes, and holds the console core in
// reset while the clock is changed. Runs on the 50 MHz reference clock.
//
// Ports:
//   clk              in  : 50 MHz reference clock
//   reset_n          in  : asynchronous active-low reset
//   pal              in  : video standard (1 = PAL), asynchronous
//   pll_locked       in  : PLL lock, asynchronous (used only with the macro)
//   mgmt_waitrequest in  : reconfiguration port stall
//   mgmt_write       out : write strobe
//   mgmt_address     out : register address (6 bits)
//   mgmt_writedata   out : register data (32 bits)
//   tv_reset         out : active-high reset to the console core
//   busy             out : sequence in progress
//
// Optional feature macro: CHF_PLL_LOCK_WAIT_EN
//   When defined, after START is accepted the sequencer waits in LOCKWAIT
//   for the PLL to lose and regain lock (16 stable cycles) or for
//   LOCK_TIMEOUT cycles before releasing tv_reset.
module chf_pll_reconfig
  import chf_pll_pkg::*;
#(
  parameter logic [31:0] N_CNT        = 32'h00010000,
  parameter logic [31:0] M_CNT        = 32'h00000404,
  parameter logic [31:0] C0_NTSC      = 32'h00000505,
  parameter logic [31:0] C0_PAL       = 32'h00020504,
  parameter logic [31:0] MFRAC_NTSC   = 32'h9745BF27,
  parameter logic [31:0] MFRAC_PAL    = 32'hA3D709E8,
  parameter int unsigned LOCK_TIMEOUT = 1_048_575
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pal,
  input  logic        pll_locked,
  input  logic        mgmt_waitrequest,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        tv_reset,
  output logic        busy
);

  state_t state_reg, state_next;
  logic   pal_s, pal_d, lock_s;
  logic   std_reg;           // standard used by the current sequence
  logic   pending_reg, pending_next;
  logic   change, accept, restart;
  logic   lock_done, lock_timeout;
  logic [5:0]  addr_next;
  logic [31:0] data_next;

  chf_sync2 u_sync_pal (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pal),
    .q       (pal_s)
  );

  chf_sync2 u_sync_lock (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (lock_s)
  );

  assign change  = pal_s ^ pal_d;
  assign accept  = mgmt_write & ~mgmt_waitrequest;
  // A request seen now or earlier in the sequence abandons the remaining
  // writes once the current one is accepted.
  assign restart = pending_reg | change;

`ifdef CHF_PLL_LOCK_WAIT_EN
  logic        seen_low_reg;
  logic [3:0]  hi_cnt_reg;
  logic [31:0] timer_reg;

  // Lock qualification: lock must first be observed low (PLL actually
  // re-locking) and then stay high for 16 consecutive cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seen_low_reg <= 1'b0;
      hi_cnt_reg   <= 4'd0;
      timer_reg    <= 32'd0;
    end else if (state_reg != ST_LOCKWAIT) begin
      seen_low_reg <= 1'b0;
      hi_cnt_reg   <= 4'd0;
      timer_reg    <= 32'd0;
    end else begin
      timer_reg <= timer_reg + 32'd1;
      if (!lock_s) begin
        seen_low_reg <= 1'b1;
        hi_cnt_reg   <= 4'd0;
      end else if (seen_low_reg && hi_cnt_reg != 4'd15) begin
        hi_cnt_reg <= hi_cnt_reg + 4'd1;
      end
    end
  end

  assign lock_done    = seen_low_reg & lock_s & (hi_cnt_reg == 4'd15);
  assign lock_timeout = (timer_reg == LOCK_TIMEOUT - 32'd1);
`else
  logic unused_lock;
  assign unused_lock  = &{1'b0, lock_s, LOCK_TIMEOUT[0]};
  assign lock_done    = 1'b0;
  assign lock_timeout = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (change) state_next = ST_MODE;
      ST_MODE:  if (accept) state_next = restart ? ST_MODE : ST_NCNT;
      ST_NCNT:  if (accept) state_next = restart ? ST_MODE : ST_MCNT;
      ST_MCNT:  if (accept) state_next = restart ? ST_MODE : ST_C0;
      ST_C0:    if (accept) state_next = restart ? ST_MODE : ST_MFRAC;
      ST_MFRAC: if (accept) state_next = restart ? ST_MODE : ST_START;
`ifdef CHF_PLL_LOCK_WAIT_EN
      ST_START: if (accept) state_next = restart ? ST_MODE : ST_LOCKWAIT;
      ST_LOCKWAIT: begin
        if (restart)
          state_next = ST_MODE;
        else if (lock_done || lock_timeout)
          state_next = ST_IDLE;
      end
`else
      ST_START: if (accept) state_next = restart ? ST_MODE : ST_IDLE;
`endif
      default:  state_next = ST_IDLE;
    endcase
  end

  // Pending request: cleared whenever the next cycle is MODE (the standard
  // is re-latched there), otherwise accumulates requests seen mid-sequence.
  always_comb begin
    pending_next = pending_reg;
    if (state_next == ST_MODE)
      pending_next = 1'b0;
    else if (change && state_reg != ST_IDLE)
      pending_next = 1'b1;
  end

  // Write address/data for the state being entered; outputs are registered
  // so they line up with state_reg.
  always_comb begin
    addr_next = 6'd0;
    data_next = 32'd0;
    case (state_next)
      ST_MODE:  begin addr_next = ADDR_MODE;  data_next = 32'd0; end
      ST_NCNT:  begin addr_next = ADDR_N;     data_next = N_CNT; end
      ST_MCNT:  begin addr_next = ADDR_M;     data_next = M_CNT; end
      ST_C0:    begin addr_next = ADDR_C0;    data_next = std_reg ? C0_PAL : C0_NTSC; end
      ST_MFRAC: begin addr_next = ADDR_MFRAC; data_next = std_reg ? MFRAC_PAL : MFRAC_NTSC; end
      ST_START: begin addr_next = ADDR_START; data_next = 32'd0; end
      default:  begin addr_next = 6'd0;       data_next = 32'd0; end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_MODE;
      pal_d          <= 1'b0;
      std_reg        <= 1'b0;
      pending_reg    <= 1'b0;
      mgmt_write     <= 1'b0;
      mgmt_address   <= 6'd0;
      mgmt_writedata <= 32'd0;
      tv_reset       <= 1'b1;
      busy           <= 1'b1;
    end else begin
      state_reg      <= state_next;
      pal_d          <= pal_s;
      pending_reg    <= pending_next;
      if (state_next == ST_MODE)
        std_reg <= pal_s;
      mgmt_write     <= is_write_state(state_next);
      mgmt_address   <= addr_next;
      mgmt_writedata <= data_next;
      tv_reset       <= (state_next != ST_IDLE);
      busy           <= (state_next != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_chf_pll_reconfig.sv
// tb_chf_pll_reconfig
// Directed bench for chf_pll_reconfig. Outputs are sampled on the falling
// clock edge; inputs change on the falling edge. With CHF_PLL_LOCK_WAIT_EN
// defined, the lock-wait scenarios are exercised as well.
module tb_chf_pll_reconfig;

  logic        clk;
  logic        reset_n;
  logic        pal;
  logic        pll_locked;
  logic        mgmt_waitrequest;
  logic        mgmt_write;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        tv_reset;
  logic        busy;

  int n_cmp;
  int n_err;
  int n;

  chf_pll_reconfig #(
    .LOCK_TIMEOUT (300)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .pal              (pal),
    .pll_locked       (pll_locked),
    .mgmt_waitrequest (mgmt_waitrequest),
    .mgmt_write       (mgmt_write),
    .mgmt_address     (mgmt_address),
    .mgmt_writedata   (mgmt_writedata),
    .tv_reset         (tv_reset),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait for the next write that will be accepted on the coming rising edge,
  // then check its address/data. n = falling edges waited.
  task automatic expect_write(input string tag, input logic [5:0] a,
                              input logic [31:0] d, output int nw);
    logic found;
    found = 1'b0;
    nw = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      nw++;
      if (mgmt_write && !mgmt_waitrequest) found = 1'b1;
    end
    chk({tag, "_seen"}, {31'd0, found}, 32'd1);
    chk({tag, "_addr"}, {26'd0, mgmt_address}, {26'd0, a});
    chk({tag, "_data"}, mgmt_writedata, d);
    chk({tag, "_tvrst"}, {31'd0, tv_reset}, 32'd1);
    $display("write %s: addr=%0d data=%h after %0d cycles", tag, mgmt_address, mgmt_writedata, nw);
  endtask

  task automatic end_sequence(input string tag);
`ifdef CHF_PLL_LOCK_WAIT_EN
    logic done;
    done = 1'b0;
    pll_locked = 1'b0;
    repeat (4) @(negedge clk);
    pll_locked = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!tv_reset) done = 1'b1;
    end
    chk({tag, "_lock_release"}, {31'd0, done}, 32'd1);
`else
    @(negedge clk);
`endif
    chk({tag, "_tvrst_low"}, {31'd0, tv_reset}, 32'd0);
    chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    chk({tag, "_write_low"}, {31'd0, mgmt_write}, 32'd0);
    $display("sequence %s complete", tag);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_write"}, {31'd0, mgmt_write}, 32'd0);
    chk({tag, "_addr"}, {26'd0, mgmt_address}, 32'd0);
    chk({tag, "_data"}, mgmt_writedata, 32'd0);
    chk({tag, "_tvrst"}, {31'd0, tv_reset}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic ntsc_sequence(input string tag);
    expect_write({tag, "_mode"}, 6'd0, 32'h00000000, n);
    chk({tag, "_mode_lat"}, n, 1);
    expect_write({tag, "_ncnt"}, 6'd3, 32'h00010000, n);
    chk({tag, "_ncnt_b2b"}, n, 1);
    expect_write({tag, "_mcnt"}, 6'd4, 32'h00000404, n);
    chk({tag, "_mcnt_b2b"}, n, 1);
    expect_write({tag, "_c0"}, 6'd5, 32'h00000505, n);
    chk({tag, "_c0_b2b"}, n, 1);
    expect_write({tag, "_mfrac"}, 6'd7, 32'h9745BF27, n);
    chk({tag, "_mfrac_b2b"}, n, 1);
    expect_write({tag, "_start"}, 6'd2, 32'h00000000, n);
    chk({tag, "_start_b2b"}, n, 1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    pal = 1'b0;
    pll_locked = 1'b1;
    mgmt_waitrequest = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    reset_n = 1'b1;

    // Initial programming, NTSC
    ntsc_sequence("t1");
    end_sequence("t1");

    // PAL change from IDLE
    repeat (3) @(negedge clk);
    pal = 1'b1;
    expect_write("t2_mode", 6'd0, 32'h00000000, n);
    chk("t2_latency_max", {31'd0, n <= 4}, 32'd1);
    chk("t2_latency_min", {31'd0, n >= 3}, 32'd1);
    expect_write("t2_ncnt", 6'd3, 32'h00010000, n);
    expect_write("t2_mcnt", 6'd4, 32'h00000404, n);
    expect_write("t2_c0", 6'd5, 32'h00020504, n);
    expect_write("t2_mfrac", 6'd7, 32'hA3D709E8, n);
    expect_write("t2_start", 6'd2, 32'h00000000, n);
    end_sequence("t2");

    // Back to NTSC with the MCNT write stalled for 5 cycles
    pal = 1'b0;
    expect_write("t3_mode", 6'd0, 32'h00000000, n);
    expect_write("t3_ncnt", 6'd3, 32'h00010000, n);
    @(negedge clk);
    mgmt_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_write", {31'd0, mgmt_write}, 32'd1);
      chk("t3_stall_addr", {26'd0, mgmt_address}, 32'd4);
      chk("t3_stall_data", mgmt_writedata, 32'h00000404);
      $display("stall cycle %0d: write=%0d addr=%0d data=%h", i, mgmt_write, mgmt_address, mgmt_writedata);
      @(negedge clk);
    end
    mgmt_waitrequest = 1'b0;
    chk("t3_release_addr", {26'd0, mgmt_address}, 32'd4);
    expect_write("t3_c0", 6'd5, 32'h00000505, n);
    chk("t3_single_mcnt", n, 1);
    expect_write("t3_mfrac", 6'd7, 32'h9745BF27, n);
    expect_write("t3_start", 6'd2, 32'h00000000, n);
    end_sequence("t3");

    // Reset asserted mid-sequence
    pal = 1'b1;
    expect_write("t6_mode", 6'd0, 32'h00000000, n);
    expect_write("t6_ncnt", 6'd3, 32'h00010000, n);
    @(negedge clk);
    chk("t6_pre_write", {31'd0, mgmt_write}, 32'd1);
    chk("t6_pre_addr", {26'd0, mgmt_address}, 32'd4);
    reset_n = 1'b0;
    pal = 1'b0;
    #1;
    check_reset_values("t6_rst");
    @(negedge clk);
    reset_n = 1'b1;
    ntsc_sequence("t6");
    end_sequence("t6");

    // Change during NCNT: restart with PAL, no stale NTSC writes
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    expect_write("t4_mode", 6'd0, 32'h00000000, n);
    expect_write("t4_ncnt", 6'd3, 32'h00010000, n);
    mgmt_waitrequest = 1'b1;
    pal = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t4_ncnt_held", {26'd0, mgmt_address}, 32'd3);
    end
    mgmt_waitrequest = 1'b0;
    expect_write("t4_restart_mode", 6'd0, 32'h00000000, n);
    chk("t4_restart_b2b", n, 1);
    expect_write("t4_ncnt2", 6'd3, 32'h00010000, n);
    expect_write("t4_mcnt2", 6'd4, 32'h00000404, n);
    expect_write("t4_c0_pal", 6'd5, 32'h00020504, n);
    expect_write("t4_mfrac_pal", 6'd7, 32'hA3D709E8, n);
    expect_write("t4_start", 6'd2, 32'h00000000, n);
    end_sequence("t4");

`ifdef CHF_PLL_LOCK_WAIT_EN
    // Lock lost after START, regained after 100 cycles
    pal = 1'b0;
    expect_write("t5_mode", 6'd0, 32'h00000000, n);
    expect_write("t5_ncnt", 6'd3, 32'h00010000, n);
    expect_write("t5_mcnt", 6'd4, 32'h00000404, n);
    expect_write("t5_c0", 6'd5, 32'h00000505, n);
    expect_write("t5_mfrac", 6'd7, 32'h9745BF27, n);
    expect_write("t5_start", 6'd2, 32'h00000000, n);
    pll_locked = 1'b0;
    repeat (100) @(negedge clk);
    chk("t5_wait_write", {31'd0, mgmt_write}, 32'd0);
    chk("t5_wait_tvrst", {31'd0, tv_reset}, 32'd1);
    pll_locked = 1'b1;
    repeat (17) @(negedge clk);
    chk("t5_lock_before", {31'd0, tv_reset}, 32'd1);
    @(negedge clk);
    chk("t5_lock_after", {31'd0, tv_reset}, 32'd0);
    $display("lock wait: tv_reset=%0d after lock stable", tv_reset);

    // Lock stuck low: timeout releases tv_reset
    pal = 1'b1;
    expect_write("t5b_mode", 6'd0, 32'h00000000, n);
    expect_write("t5b_ncnt", 6'd3, 32'h00010000, n);
    expect_write("t5b_mcnt", 6'd4, 32'h00000404, n);
    expect_write("t5b_c0", 6'd5, 32'h00020504, n);
    expect_write("t5b_mfrac", 6'd7, 32'hA3D709E8, n);
    expect_write("t5b_start", 6'd2, 32'h00000000, n);
    pll_locked = 1'b0;
    repeat (300) @(negedge clk);
    chk("t5b_timeout_before", {31'd0, tv_reset}, 32'd1);
    @(negedge clk);
    chk("t5b_timeout_after", {31'd0, tv_reset}, 32'd0);
    $display("lock timeout: tv_reset=%0d", tv_reset);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
